maze_player_ctrl: RTL and testbench
===================================

Name: maze_player_ctrl

Overview:
- Player-movement stage that sits directly upstream of the VGA renderer in the maze game.
- Consumes single-cycle, already-debounced button pulses and checks each move against the 30x20 maze wall map, read one row at a time from the synchronous map ROM.
- Produces the player's cell position, its pixel origin for the renderer, a move counter for the 7-segment display, and a win pulse.

Parameters:
- COLS, 30, maze width in cells; one map word bit per column.
- ROWS, 20, maze height in cells; one map word per row.
- START_X, 1, column of the start cell.
- START_Y, 1, row of the start cell.
- GOAL_X, 28, column of the goal cell.
- GOAL_Y, 18, row of the goal cell.
- CELL_W, 20, pixel width of one cell.
- CELL_H, 24, pixel height of one cell.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- BtnU  in  1  one-cycle pulse: move up (y-1).
- BtnD  in  1  one-cycle pulse: move down (y+1).
- BtnL  in  1  one-cycle pulse: move left (x-1).
- BtnR  in  1  one-cycle pulse: move right (x+1).
- BtnC  in  1  one-cycle pulse: restart the game.
- map_addr  out  5  row address to the map ROM.
- map_data  in  30  map ROM row; bit x=1 means column x is a wall; bit 0 is the leftmost column.
- player_x  out  5  current column.
- player_y  out  5  current row.
- player_px  out  10  player_x*CELL_W.
- player_py  out  10  player_y*CELL_H.
- move_count  out  16  number of accepted moves, saturating.
- busy  out  1  high while a move lookup is in flight.
- blocked  out  1  one-cycle pulse when a move is rejected.
- win  out  1  one-cycle pulse on reaching the goal.

Behaviour:
- Reset (Reset=0, asynchronous): player_x=START_X, player_y=START_Y, player_px/player_py set to the matching pixel values, move_count=0, busy=0, blocked=0, win=0, state=IDLE, map_addr=START_Y.
- Map ROM timing: the ROM is registered with 1-cycle latency. map_data is valid in the cycle after map_addr is presented.
- States: IDLE, RD, CHK, DONE.

IDLE:
- map_addr = player_y.
- Button priority when several fire in the same edge: BtnC > BtnU > BtnD > BtnL > BtnR. Only one request is taken.
- Edge check: a request that would leave the grid is rejected without a ROM read. The out-of-grid cases are x=0 with L, x=COLS-1 with R, y=0 with U, and y=ROWS-1 with D.
- Rejected request: pulse blocked for 1 cycle and stay in IDLE.
- Valid request: latch tgt_x/tgt_y and go to RD.
- BtnC: return to start position and clear move_count in one cycle, with no ROM read.

RD:
- map_addr = tgt_y, busy=1.
- Next state is CHK.

CHK:
- map_addr is held at tgt_y and map_data is valid; busy=1.
- If map_data[tgt_x]=1: pulse blocked and go to IDLE.
- Otherwise, at this edge: player_x/player_y <= tgt, player_px/player_py updated, move_count += 1 (saturates at 16'hFFFF).
- If tgt equals (GOAL_X, GOAL_Y): pulse win and go to DONE. Otherwise go to IDLE.

Latency:
- Button sampled at edge N.
- Position, blocked or win visible after edge N+2.
- busy is high during cycles N+1 and N+2.

Other rules:
- Buttons are ignored while busy; they are not queued.
- BtnC during RD/CHK aborts the lookup: return to start, clear move_count, go to IDLE, no blocked/win pulse.
- DONE: all movement buttons are ignored and outputs hold. BtnC restarts and goes to IDLE.
- Pixel products are computed from the registered cell value and updated in the same edge as player_x/player_y.
- Reset asserted mid-lookup forces the reset values immediately, with no pulses.

Test Plan:
- Reset, then release: player_x=1, player_y=1, player_px=20, player_py=24, move_count=0, map_addr=1, busy=0.
- Open cell (row 1 bit 2 = 0), BtnR pulse at edge N: busy high for 2 cycles; after N+2, player_x=2, player_px=40, move_count=1, no blocked.
- Wall cell (row 0 bit 1 = 1), BtnU from (1,1): map_addr=0 during RD/CHK; blocked pulses once; position unchanged; move_count unchanged.
- Grid edge, player at x=0, BtnL: blocked on the next cycle; busy never asserts; map_addr stays at player_y.
- BtnU and BtnR in the same edge with both cells open: only the up move is taken (y-1); a BtnR pulse during busy is dropped; move_count +1.
- Goal and restart: walk to (28,18) → win pulses once and state is DONE; BtnD is then ignored. BtnC → (1,1), move_count=0. BtnC during RD → no win/blocked pulse, back at start.

Source files
------------

// File: rtl/maze_player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maze_player_ctrl
//  Purpose  : Player-movement stage feeding the VGA maze renderer. Takes
//             single-cycle debounced button pulses, checks each requested
//             move against the wall map (one row per read from a synchronous
//             map ROM) and maintains the player's cell position, its pixel
//             origin, a saturating move counter and a win pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk         in   1     system clock
//    Reset       in   1     asynchronous, active-low reset
//    BtnU/D/L/R  in   1     one-cycle move pulses (up=y-1, down=y+1,
//                           left=x-1, right=x+1)
//    BtnC        in   1     one-cycle restart pulse
//    map_addr    out  5     row address presented to the map ROM
//    map_data    in   COLS  map ROM row, bit x=1 -> column x is a wall
//    player_x    out  5     current column
//    player_y    out  5     current row
//    player_px   out  10    player_x * CELL_W
//    player_py   out  10    player_y * CELL_H
//    move_count  out  16    accepted moves, saturating at 16'hFFFF
//    busy        out  1     high while a wall lookup is in flight
//    blocked     out  1     one-cycle pulse on a rejected move
//    win         out  1     one-cycle pulse on reaching the goal cell
// ============================================================================
module maze_player_ctrl #(
  parameter int COLS    = 30,
  parameter int ROWS    = 20,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 28,
  parameter int GOAL_Y  = 18,
  parameter int CELL_W  = 20,
  parameter int CELL_H  = 24
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            BtnU,
  input  logic            BtnD,
  input  logic            BtnL,
  input  logic            BtnR,
  input  logic            BtnC,
  output logic [4:0]      map_addr,
  input  logic [COLS-1:0] map_data,
  output logic [4:0]      player_x,
  output logic [4:0]      player_y,
  output logic [9:0]      player_px,
  output logic [9:0]      player_py,
  output logic [15:0]     move_count,
  output logic            busy,
  output logic            blocked,
  output logic            win
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;  // waiting for a button
  localparam logic [1:0] RD   = 2'd1;  // target row address presented to ROM
  localparam logic [1:0] CHK  = 2'd2;  // ROM row valid, decide the move
  localparam logic [1:0] DONE = 2'd3;  // goal reached, only restart accepted

  // --------------------------------------------------------------------------
  // Fixed-width views of the geometry parameters
  // --------------------------------------------------------------------------
  localparam logic [4:0]  START_COL = 5'(START_X);
  localparam logic [4:0]  START_ROW = 5'(START_Y);
  localparam logic [4:0]  GOAL_COL  = 5'(GOAL_X);
  localparam logic [4:0]  GOAL_ROW  = 5'(GOAL_Y);
  localparam logic [4:0]  COL_MAX   = 5'(COLS - 1);
  localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);
  localparam logic [9:0]  CELL_W_PX = 10'(CELL_W);
  localparam logic [9:0]  CELL_H_PX = 10'(CELL_H);
  localparam logic [9:0]  START_PX  = 10'(START_X * CELL_W);
  localparam logic [9:0]  START_PY  = 10'(START_Y * CELL_H);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0] state;
  logic [4:0] tgt_x;
  logic [4:0] tgt_y;

  // --------------------------------------------------------------------------
  // Request decode (only acted on in IDLE)
  // The priority chain U > D > L > R guarantees a single request is taken
  // when several pulses coincide; BtnC is handled ahead of all of them in the
  // sequential block. A request that would leave the grid is flagged as an
  // edge hit so it can be rejected without spending a ROM read.
  // --------------------------------------------------------------------------
  logic       req_move;
  logic       req_edge;
  logic [4:0] req_x;
  logic [4:0] req_y;

  always_comb begin
    req_move = 1'b0;
    req_edge = 1'b0;
    req_x    = player_x;
    req_y    = player_y;
    if (BtnU) begin
      if (player_y == 5'd0) begin
        req_edge = 1'b1;
      end else begin
        req_move = 1'b1;
        req_y    = player_y - 5'd1;
      end
    end else if (BtnD) begin
      if (player_y == ROW_MAX) begin
        req_edge = 1'b1;
      end else begin
        req_move = 1'b1;
        req_y    = player_y + 5'd1;
      end
    end else if (BtnL) begin
      if (player_x == 5'd0) begin
        req_edge = 1'b1;
      end else begin
        req_move = 1'b1;
        req_x    = player_x - 5'd1;
      end
    end else if (BtnR) begin
      if (player_x == COL_MAX) begin
        req_edge = 1'b1;
      end else begin
        req_move = 1'b1;
        req_x    = player_x + 5'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lookup result
  // --------------------------------------------------------------------------
  logic lookup;
  logic wall_hit;
  logic at_goal;

  assign lookup   = (state == RD) || (state == CHK);
  assign wall_hit = map_data[tgt_x];
  assign at_goal  = (tgt_x == GOAL_COL) && (tgt_y == GOAL_ROW);

  // The ROM address follows the target row for the whole lookup so the row
  // registered at the end of RD stays the one being examined in CHK; outside
  // a lookup it tracks the player's own row.
  assign map_addr = lookup ? tgt_y : player_y;
  assign busy     = lookup;

  // --------------------------------------------------------------------------
  // Main sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      tgt_x      <= START_COL;
      tgt_y      <= START_ROW;
      player_x   <= START_COL;
      player_y   <= START_ROW;
      player_px  <= START_PX;
      player_py  <= START_PY;
      move_count <= 16'd0;
      blocked    <= 1'b0;
      win        <= 1'b0;
    end else begin
      // Both status outputs are single-cycle pulses by default.
      blocked <= 1'b0;
      win     <= 1'b0;

      if (BtnC) begin
        // Restart wins from every state, including an in-flight lookup,
        // which is simply abandoned without any pulse.
        state      <= IDLE;
        player_x   <= START_COL;
        player_y   <= START_ROW;
        player_px  <= START_PX;
        player_py  <= START_PY;
        move_count <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            if (req_edge) begin
              blocked <= 1'b1;
            end else if (req_move) begin
              tgt_x <= req_x;
              tgt_y <= req_y;
              state <= RD;
            end
          end

          RD: begin
            // Buttons are deliberately ignored here; nothing is queued.
            state <= CHK;
          end

          CHK: begin
            if (wall_hit) begin
              blocked <= 1'b1;
              state   <= IDLE;
            end else begin
              player_x  <= tgt_x;
              player_y  <= tgt_y;
              // Pixel origins come from the registered target so they change
              // on the same edge as the cell coordinates.
              player_px <= {5'd0, tgt_x} * CELL_W_PX;
              player_py <= {5'd0, tgt_y} * CELL_H_PX;
              if (move_count != COUNT_MAX) begin
                move_count <= move_count + 16'd1;
              end
              if (at_goal) begin
                win   <= 1'b1;
                state <= DONE;
              end else begin
                state <= IDLE;
              end
            end
          end

          DONE: begin
            // Game over: hold everything until a restart.
            state <= DONE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_player_ctrl
//  Purpose  : Self-checking bench for maze_player_ctrl. Models the registered
//             map ROM, runs directed multi-cycle sequences, a table of
//             single-move vectors, and a randomized walk compared against a
//             transaction-level model of the game rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maze_player_ctrl;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  btn;
  logic [4:0]  map_addr;
  logic [29:0] map_data;
  logic [4:0]  player_x;
  logic [4:0]  player_y;
  logic [9:0]  player_px;
  logic [9:0]  player_py;
  logic [15:0] move_count;
  logic        busy;
  logic        blocked;
  logic        win;

  logic [29:0] maze [20];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 Clk = ~Clk;

  maze_player_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnU       (btn[3]),
    .BtnD       (btn[2]),
    .BtnL       (btn[1]),
    .BtnR       (btn[0]),
    .BtnC       (btn[4]),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .player_x   (player_x),
    .player_y   (player_y),
    .player_px  (player_px),
    .player_py  (player_py),
    .move_count (move_count),
    .busy       (busy),
    .blocked    (blocked),
    .win        (win)
  );

  // Registered map ROM, one cycle of latency.
  always @(posedge Clk) begin
    map_data <= (map_addr < 5'd20) ? maze[map_addr] : '1;
  end

  // Row 0 is wall except column 29, row 1 and columns 28/29 are open
  // corridors (path to the goal), everything else is a sparse wall pattern.
  function automatic bit cell_open(input int x, input int y);
    if (y == 0)             return (x == 29);
    if (y == 1 || x >= 28)  return 1'b1;
    return ((x * 7 + y * 3) % 5) != 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int ex, input int ey, input int ec,
                             input int ebusy, input int eblk, input int ewin, input int eaddr);
    chk($sformatf("%s x", tag),       32'(player_x),   ex);
    chk($sformatf("%s y", tag),       32'(player_y),   ey);
    chk($sformatf("%s px", tag),      32'(player_px),  ex * 20);
    chk($sformatf("%s py", tag),      32'(player_py),  ey * 24);
    chk($sformatf("%s count", tag),   32'(move_count), ec);
    chk($sformatf("%s busy", tag),    32'(busy),       ebusy);
    chk($sformatf("%s blocked", tag), 32'(blocked),    eblk);
    chk($sformatf("%s win", tag),     32'(win),        ewin);
    chk($sformatf("%s map_addr", tag),32'(map_addr),   eaddr);
  endtask

  // Drive a one-cycle button pulse; returns at the falling edge after the
  // sampling edge.
  task automatic pulse(input logic [4:0] b);
    @(negedge Clk);
    btn = b;
    @(negedge Clk);
    btn = 5'd0;
  endtask

  // Pulse and watch four cycles, counting status pulses.
  task automatic do_move(input logic [4:0] b, output int nblk, output int nwin);
    nblk = 0;
    nwin = 0;
    pulse(b);
    for (int i = 0; i < 4; i++) begin
      nblk += int'(blocked);
      nwin += int'(win);
      if (i < 3) @(negedge Clk);
    end
  endtask

  typedef struct {
    logic [4:0] b;
    int ex;
    int ey;
    int ec;
    int eblk;
    int ewin;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nw, sb, sw;
    int mx, my, mc;
    bit mdone;

    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 30; x++)
        maze[y][x] = !cell_open(x, y);

    btn   = 5'd0;
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_state("in reset", 1, 1, 0, 0, 0, 0, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check_state("after reset", 1, 1, 0, 0, 0, 0, 1);

    // Open cell: right move latency and busy window.
    @(negedge Clk); btn = B_R;
    @(negedge Clk); btn = 5'd0;
    check_state("R rd", 1, 1, 0, 1, 0, 0, 1);
    @(negedge Clk);
    check_state("R chk", 1, 1, 0, 1, 0, 0, 1);
    @(negedge Clk);
    check_state("R done", 2, 1, 1, 0, 0, 0, 1);
    pulse(B_C);
    check_state("restart", 1, 1, 0, 0, 0, 0, 1);

    // Wall above the start cell.
    pulse(B_U);
    check_state("wall rd", 1, 1, 0, 1, 0, 0, 0);
    @(negedge Clk);
    check_state("wall chk", 1, 1, 0, 1, 0, 0, 0);
    @(negedge Clk);
    check_state("wall out", 1, 1, 0, 0, 1, 0, 1);
    @(negedge Clk);
    check_state("wall end", 1, 1, 0, 0, 0, 0, 1);

    // Grid edge on the left.
    do_move(B_L, nb, nw);
    check_state("to x0", 0, 1, 1, 0, 0, 0, 1);
    pulse(B_L);
    check_state("edge", 0, 1, 1, 0, 1, 0, 1);
    @(negedge Clk);
    check_state("edge end", 0, 1, 1, 0, 0, 0, 1);

    // Table of single moves starting from the start cell.
    vecs[0] = '{B_R,       2, 1, 1, 0, 0};
    vecs[1] = '{B_L,       1, 1, 2, 0, 0};
    vecs[2] = '{B_U,       1, 1, 2, 1, 0};
    vecs[3] = '{B_L,       0, 1, 3, 0, 0};
    vecs[4] = '{B_L,       0, 1, 3, 1, 0};
    vecs[5] = '{B_U | B_R, 0, 1, 3, 1, 0};
    vecs[6] = '{B_C,       1, 1, 0, 0, 0};
    vecs[7] = '{B_D,       1, 2, 1, 0, 0};
    vecs[8] = '{B_C | B_L, 1, 1, 0, 0, 0};
    vecs[9] = '{B_L | B_R, 0, 1, 1, 0, 0};
    pulse(B_C);
    for (int i = 0; i < 10; i++) begin
      do_move(vecs[i].b, nb, nw);
      chk($sformatf("vec%0d x", i),       32'(player_x),   vecs[i].ex);
      chk($sformatf("vec%0d y", i),       32'(player_y),   vecs[i].ey);
      chk($sformatf("vec%0d count", i),   32'(move_count), vecs[i].ec);
      chk($sformatf("vec%0d blocked", i), nb,              vecs[i].eblk);
      chk($sformatf("vec%0d win", i),     nw,              vecs[i].ewin);
    end

    // Up beats right; a right pulse during the lookup is dropped.
    pulse(B_C);
    do_move(B_R, nb, nw);
    do_move(B_R, nb, nw);
    do_move(B_D, nb, nw);
    check_state("at 3,2", 3, 2, 3, 0, 0, 0, 2);
    @(negedge Clk); btn = B_U | B_R;
    @(negedge Clk); btn = B_R;
    check_state("prio rd", 3, 2, 3, 1, 0, 0, 1);
    @(negedge Clk); btn = 5'd0;
    check_state("prio chk", 3, 2, 3, 1, 0, 0, 1);
    @(negedge Clk);
    check_state("prio done", 3, 1, 4, 0, 0, 0, 1);
    repeat (3) @(negedge Clk);
    check_state("prio hold", 3, 1, 4, 0, 0, 0, 1);

    // Walk to the goal.
    pulse(B_C);
    sb = 0; sw = 0;
    for (int i = 0; i < 27; i++) begin
      do_move(B_R, nb, nw); sb += nb; sw += nw;
    end
    for (int i = 0; i < 17; i++) begin
      do_move(B_D, nb, nw); sb += nb; sw += nw;
    end
    chk("goal last win", nw, 1);
    chk("goal total win", sw, 1);
    chk("goal total blocked", sb, 0);
    check_state("goal", 28, 18, 44, 0, 0, 0, 18);
    do_move(B_D, nb, nw);
    check_state("done hold", 28, 18, 44, 0, 0, 0, 18);
    chk("done blocked", nb, 0);
    chk("done win", nw, 0);
    pulse(B_C);
    check_state("done restart", 1, 1, 0, 0, 0, 0, 1);
    do_move(B_R, nb, nw);
    check_state("move after restart", 2, 1, 1, 0, 0, 0, 1);

    // Restart during the read cycle aborts the lookup.
    @(negedge Clk); btn = B_R;
    @(negedge Clk); btn = B_C;
    check_state("abort rd", 2, 1, 1, 1, 0, 0, 1);
    @(negedge Clk); btn = 5'd0;
    check_state("abort", 1, 1, 0, 0, 0, 0, 1);
    sb = 0; sw = 0;
    repeat (3) begin
      @(negedge Clk);
      sb += int'(blocked); sw += int'(win);
    end
    chk("abort blocked", sb, 0);
    chk("abort win", sw, 0);

    // Asynchronous reset in the middle of a lookup.
    do_move(B_R, nb, nw);
    @(negedge Clk); btn = B_R;
    @(negedge Clk); btn = 5'd0;
    #2 Reset = 1'b0;
    #1 check_state("async reset", 1, 1, 0, 0, 0, 0, 1);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    check_state("async release", 1, 1, 0, 0, 0, 0, 1);

    // Randomized walk against a transaction-level rules model.
    pulse(B_C);
    mx = 1; my = 1; mc = 0; mdone = 1'b0;
    for (int it = 0; it < 400; it++) begin
      logic [4:0] b;
      int r, kind, tx, ty, act;
      bit w;
      r = $urandom_range(0, 31);
      if (r == 0)      b = B_C;
      else if (r < 6)  b = {1'b0, 4'($urandom_range(0, 15))};
      else             b = 5'(1 << $urandom_range(0, 3));
      kind = $urandom_range(0, 11);
      tx = mx; ty = my;
      if (b[4])                          act = 0;
      else if (mdone || b[3:0] == 4'd0)  act = 1;
      else begin
        if (b[3])      ty = my - 1;
        else if (b[2]) ty = my + 1;
        else if (b[1]) tx = mx - 1;
        else           tx = mx + 1;
        act = (tx < 0 || tx >= 30 || ty < 0 || ty >= 20) ? 2 : 3;
      end

      @(negedge Clk); btn = b;
      @(negedge Clk); btn = 5'd0;
      case (act)
        0: begin
          mx = 1; my = 1; mc = 0; mdone = 1'b0;
          check_state("rnd restart", mx, my, mc, 0, 0, 0, my);
        end
        1: check_state("rnd idle", mx, my, mc, 0, 0, 0, my);
        2: check_state("rnd edge", mx, my, mc, 0, 1, 0, my);
        default: begin
          check_state("rnd rd", mx, my, mc, 1, 0, 0, ty);
          if (kind == 0)      btn = B_C;
          else if (kind == 1) btn = 5'(1 << $urandom_range(0, 3));
          @(negedge Clk); btn = 5'd0;
          if (kind == 0) begin
            mx = 1; my = 1; mc = 0; mdone = 1'b0;
            check_state("rnd abort", mx, my, mc, 0, 0, 0, my);
          end else begin
            check_state("rnd chk", mx, my, mc, 1, 0, 0, ty);
            if (kind == 2) btn = {1'b0, 4'($urandom_range(1, 15))};
            @(negedge Clk); btn = 5'd0;
            if (maze[ty][tx]) begin
              check_state("rnd wall", mx, my, mc, 0, 1, 0, my);
            end else begin
              mx = tx; my = ty;
              if (mc < 65535) mc++;
              w = (mx == 28) && (my == 18);
              if (w) mdone = 1'b1;
              check_state("rnd move", mx, my, mc, 0, 0, int'(w), my);
            end
          end
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
